game_round_countdown: RTL and testbench

//   Round countdown peripheral for party-game rounds. It consumes the timeout output of the

---
 rtl/game_round_countdown_if.sv | 11 +
 rtl/game_round_countdown.sv | 117 +++++++++++
 tb/tb_game_round_countdown.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/game_round_countdown_if.sv
// Avalon-MM style 16-bit register bus for the round countdown peripheral.
interface game_round_countdown_if;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [15:0] writedata;
    logic [15:0] readdata;

    modport master (output address, chipselect, write_n, writedata, input readdata);
    modport slave  (input address, chipselect, write_n, writedata, output readdata);
endinterface

// File: rtl/game_round_countdown.sv
// Round countdown: counts whole game seconds from upstream tick edges, raises irq on expiry
// and warn near the end of a running round.
module game_round_countdown #(
    parameter int TICKS_PER_SEC = 20,
    parameter int SEC_W         = 10,
    parameter int DEFAULT_SECS  = 60,
    parameter int WARN_SECS     = 5
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  tick_in,
    game_round_countdown_if.slave bus,
    output logic                  irq,
    output logic                  warn
);
    typedef enum logic [1:0] {IDLE, RUNNING, PAUSED, EXPIRED} state_t;

    localparam logic [SEC_W-1:0] LOAD_RST = SEC_W'(DEFAULT_SECS);
    localparam logic [SEC_W-1:0] WARN_V   = SEC_W'(WARN_SECS);
    localparam logic [15:0]      SUB_MAX  = 16'(TICKS_PER_SEC - 1);

    state_t           state;
    logic [SEC_W-1:0] remaining;
    logic [SEC_W-1:0] load_r;
    logic [15:0]      subcount;
    logic             expired;
    logic             irq_en;
    logic             tick_d;

    logic wr, wr_status, wr_ctrl, wr_load;
    logic start_s, stop_s, pause_s, resume_s;
    logic tick_ev;
    logic [15:0] rd_mux;
    logic unused_ok;

    assign wr        = bus.chipselect && !bus.write_n;
    assign wr_status = wr && (bus.address == 3'd0);
    assign wr_ctrl   = wr && (bus.address == 3'd1);
    assign wr_load   = wr && (bus.address == 3'd2);

    // One strobe wins per write: START > STOP > PAUSE > RESUME.
    assign start_s  = wr_ctrl && bus.writedata[1];
    assign stop_s   = wr_ctrl && bus.writedata[2] && !bus.writedata[1];
    assign pause_s  = wr_ctrl && bus.writedata[3] && !bus.writedata[2] && !bus.writedata[1];
    assign resume_s = wr_ctrl && bus.writedata[4] && !bus.writedata[3] && !bus.writedata[2]
                      && !bus.writedata[1];

    assign tick_ev   = tick_in && !tick_d;
    assign irq       = expired && irq_en;
    assign unused_ok = &{1'b0, bus.writedata};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            remaining <= '0;
            subcount  <= '0;
            expired   <= 1'b0;
            irq_en    <= 1'b0;
            load_r    <= LOAD_RST;
            warn      <= 1'b0;
            tick_d    <= 1'b0;
        end else begin
            tick_d <= tick_in;
            warn   <= (state == RUNNING) && (remaining <= WARN_V) && (remaining != '0);
            if (wr_load)   load_r  <= bus.writedata[SEC_W-1:0];
            if (wr_ctrl)   irq_en  <= bus.writedata[0];
            // Cleared first so a same-cycle expiry below overrides it.
            if (wr_status) expired <= 1'b0;

            if (start_s) begin
                remaining <= load_r;
                subcount  <= '0;
                state     <= RUNNING;
                expired   <= 1'b0;
            end else if (stop_s) begin
                state <= IDLE;
            end else begin
                case (state)
                    RUNNING: begin
                        if (remaining == '0) begin
                            state   <= EXPIRED;
                            expired <= 1'b1;
                        end else if (pause_s) begin
                            state <= PAUSED;
                        end else if (tick_ev) begin
                            if (subcount == SUB_MAX) begin
                                subcount  <= '0;
                                remaining <= remaining - 1'b1;
                            end else begin
                                subcount <= subcount + 16'd1;
                            end
                        end
                    end
                    PAUSED:  if (resume_s) state <= RUNNING;
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        rd_mux = '0;
        case (bus.address)
            3'd0: rd_mux[2:0] = {state == PAUSED, state == RUNNING, expired};
            3'd1: rd_mux[0] = irq_en;
            3'd2: rd_mux[SEC_W-1:0] = load_r;
            3'd3: rd_mux[SEC_W-1:0] = remaining;
            3'd4: rd_mux = subcount;
            default: rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) bus.readdata <= '0;
        else          bus.readdata <= rd_mux;
    end
endmodule

// File: tb/tb_game_round_countdown.sv
// Directed plus randomized bench for game_round_countdown against a tick-count reference model.
module tb_game_round_countdown;
    localparam int TPS = 20;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic tick_in = 1'b0;
    logic irq, warn;
    int   checks = 0;
    int   errors = 0;

    game_round_countdown_if bus();

    game_round_countdown #(.TICKS_PER_SEC(TPS), .SEC_W(10), .DEFAULT_SECS(60), .WARN_SECS(5)) dut (
        .clk(clk), .reset_n(reset_n), .tick_in(tick_in), .bus(bus), .irq(irq), .warn(warn)
    );

    always #5 clk = ~clk;

    // Model: a round is "base seconds" minus whole seconds worth of counted ticks.
    int m_state = 0;   // 0 idle, 1 running, 2 paused, 3 expired
    int m_load  = 60;
    int m_base  = 0;
    int m_ticks = 0;
    int m_exp   = 0;
    int m_irqen = 0;

    function automatic int m_rem();
        return m_base - m_ticks / TPS;
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_write(input logic [2:0] a, input logic [15:0] d);
        @(negedge clk);
        bus.address = a; bus.chipselect = 1'b1; bus.write_n = 1'b0; bus.writedata = d;
        @(negedge clk);
        bus.chipselect = 1'b0; bus.write_n = 1'b1;
    endtask

    task automatic do_read(input logic [2:0] a, output logic [15:0] d);
        @(negedge clk);
        bus.address = a; bus.chipselect = 1'b1; bus.write_n = 1'b1;
        @(posedge clk);
        #1 d = bus.readdata;
        bus.chipselect = 1'b0;
    endtask

    task automatic m_count_tick();
        if (m_state == 1) begin
            m_ticks++;
            if (m_rem() == 0) begin m_state = 3; m_exp = 1; end
        end
    endtask

    task automatic pulse_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk); tick_in = 1'b1;
            @(negedge clk); tick_in = 1'b0;
            m_count_tick();
        end
    endtask

    task automatic level_tick(input int cycles);
        @(negedge clk); tick_in = 1'b1;
        repeat (cycles) @(negedge clk);
        tick_in = 1'b0;
        m_count_tick();
    endtask

    task automatic ctrl(input logic [15:0] d);
        m_irqen = d[0];
        if (d[1]) begin
            m_base = m_load; m_ticks = 0; m_exp = 0; m_state = 1;
            if (m_load == 0) begin m_state = 3; m_exp = 1; end
        end else if (d[2]) m_state = 0;
        else if (d[3]) begin if (m_state == 1) m_state = 2; end
        else if (d[4]) begin if (m_state == 2) m_state = 1; end
        do_write(3'd1, d);
    endtask

    task automatic set_load(input int v);
        m_load = v;
        do_write(3'd2, 16'(v));
    endtask

    task automatic clr_status();
        m_exp = 0;
        do_write(3'd0, 16'h0);
    endtask

    task automatic check_all(input string tag);
        logic [15:0] d;
        logic w;
        repeat (2) @(negedge clk);
        do_read(3'd0, d);
        chk({tag, ".status"}, d, {13'b0, m_state == 2, m_state == 1, m_exp[0]});
        do_read(3'd1, d); chk({tag, ".control"}, d, 16'(m_irqen));
        do_read(3'd2, d); chk({tag, ".load"}, d, 16'(m_load));
        do_read(3'd3, d); chk({tag, ".remain"}, d, 16'(m_rem()));
        do_read(3'd4, d); chk({tag, ".subtick"}, d, 16'(m_ticks % TPS));
        chk({tag, ".irq"}, {15'b0, irq}, {15'b0, m_exp[0] & m_irqen[0]});
        w = (m_state == 1) && (m_rem() <= 5) && (m_rem() != 0);
        chk({tag, ".warn"}, {15'b0, warn}, {15'b0, w});
    endtask

    initial begin
        logic [15:0] d;
        bus.address = '0; bus.chipselect = 1'b0; bus.write_n = 1'b1; bus.writedata = '0;
        repeat (3) @(negedge clk);
        chk("rst.readdata", bus.readdata, 16'h0);
        reset_n = 1'b1;
        check_all("defaults");

        // Full round of three seconds
        set_load(3);
        ctrl(16'h03);
        check_all("round.t0");
        for (int s = 1; s <= 3; s++) begin
            pulse_ticks(20);
            check_all($sformatf("round.t%0d", s * 20));
        end
        chk("round.irq_hi", {15'b0, irq}, 16'h1);
        clr_status();
        chk("round.irq_drop", {15'b0, irq}, 16'h0);

        // Pause holds the count, resume continues it
        set_load(10);
        ctrl(16'h03);
        pulse_ticks(10);
        ctrl(16'h09);
        pulse_ticks(30);
        check_all("pause.hold");
        ctrl(16'h11);
        pulse_ticks(10);
        check_all("pause.resume");

        // Level held high counts once
        level_tick(100);
        check_all("level");

        // Zero load expires right after start
        set_load(0);
        ctrl(16'h03);
        @(negedge clk);
        do_read(3'd0, d);
        chk("zero.status", d, 16'h1);
        check_all("zero");
        clr_status();
        check_all("zero.clr");

        // START and STOP together: START wins
        set_load(2);
        ctrl(16'h06);
        check_all("startstop");

        // Randomized sequence
        for (int it = 0; it < 40; it++) begin
            case ($urandom_range(0, 4))
                0: set_load($urandom_range(0, 3));
                1: ctrl(16'($urandom_range(0, 31)));
                2: pulse_ticks($urandom_range(1, 45));
                3: clr_status();
                default: level_tick($urandom_range(2, 8));
            endcase
            check_all($sformatf("rand%0d", it));
        end

        // Reset in the middle of a running round
        set_load(3);
        ctrl(16'h03);
        pulse_ticks(5);
        check_all("prereset");
        @(negedge clk);
        bus.address = 3'd2; bus.chipselect = 1'b1; bus.write_n = 1'b1;
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("midrst.readdata", bus.readdata, 16'h0);
        chk("midrst.irq", {15'b0, irq}, 16'h0);
        chk("midrst.warn", {15'b0, warn}, 16'h0);
        bus.chipselect = 1'b0;
        m_state = 0; m_load = 60; m_base = 0; m_ticks = 0; m_exp = 0; m_irqen = 0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        check_all("postreset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
